// File: rtl/adc_avg_monitor.sv
// Per-channel exponential averaging of 8-channel ADC scans with hysteretic over-limit alarms.
// Define ADC_AVG_ERR_CNT_EN to build per-channel saturating conversion-error counters.
module adc_avg_monitor #(
   parameter int         K        = 4,
   parameter logic [9:0] ALARM_HI = 10'd900,
   parameter logic [9:0] ALARM_LO = 10'd800
) (
   input  logic            clk,
   input  logic            sclr,
   input  logic            adc_valid,
   input  logic [7:0][9:0] adc,
   input  logic [7:0]      err,
   output logic [7:0][9:0] avg,
   output logic [7:0]      alarm,
   output logic            avg_valid,
   output logic            busy,
   output logic            overrun,
   output logic [7:0][7:0] err_cnt
);

   localparam int AW = 10 + K;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PROC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_reg;
   state_t          state_next;
   logic [2:0]      ch_reg;
   logic [7:0][9:0] adc_snap_reg;
   logic [7:0]      err_snap_reg;
   logic            accept;

   logic [AW-1:0]   acc_reg    [8];
   logic            primed_reg [8];
   logic [9:0]      avg_reg    [8];
   logic            alarm_reg  [8];

   logic [9:0]      x_cur;
   logic [AW-1:0]   acc_cur;
   logic [AW-1:0]   acc_next;
   logic [9:0]      avg_next;
   logic            alarm_next;
   logic            upd;

   // A new scan can only be taken while no scan is being walked through the datapath.
   assign accept    = adc_valid && (state_reg != PROC);
   assign busy      = (state_reg == PROC);
   assign avg_valid = (state_reg == DONE);
   assign overrun   = adc_valid && (state_reg == PROC) && !sclr;

   always_ff @(posedge clk) begin
      if (sclr) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept) state_next = PROC;
         PROC:    if (ch_reg == 3'd7) state_next = DONE;
         DONE:    state_next = accept ? PROC : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (sclr) begin
         ch_reg       <= 3'd0;
         adc_snap_reg <= '0;
         err_snap_reg <= '0;
      end else begin
         ch_reg <= (state_reg == PROC) ? ch_reg + 3'd1 : 3'd0;
         if (accept) begin
            adc_snap_reg <= adc;
            err_snap_reg <= err;
         end
      end
   end

   // Shared filter datapath, time-multiplexed over channels by ch_reg.
   always_comb begin
      x_cur   = adc_snap_reg[ch_reg];
      acc_cur = acc_reg[ch_reg];
      if (primed_reg[ch_reg]) begin
         acc_next = acc_cur - (acc_cur >> K) + {{K{1'b0}}, x_cur};
      end else begin
         acc_next = {x_cur, {K{1'b0}}};
      end
      avg_next   = acc_next[AW-1:K];
      alarm_next = alarm_reg[ch_reg];
      if (avg_next >= ALARM_HI) begin
         alarm_next = 1'b1;
      end else if (avg_next <= ALARM_LO) begin
         alarm_next = 1'b0;
      end
      upd = (state_reg == PROC) && !err_snap_reg[ch_reg];
   end

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_ch
         logic sel;
         assign sel = upd && (ch_reg == 3'(gi));

         always_ff @(posedge clk) begin
            if (sclr) begin
               acc_reg[gi]    <= '0;
               primed_reg[gi] <= 1'b0;
               avg_reg[gi]    <= '0;
               alarm_reg[gi]  <= 1'b0;
            end else if (sel) begin
               acc_reg[gi]    <= acc_next;
               primed_reg[gi] <= 1'b1;
               avg_reg[gi]    <= avg_next;
               alarm_reg[gi]  <= alarm_next;
            end
         end

         assign avg[gi]   = avg_reg[gi];
         assign alarm[gi] = alarm_reg[gi];

`ifdef ADC_AVG_ERR_CNT_EN
         logic [7:0] cnt_reg;
         always_ff @(posedge clk) begin
            if (sclr) begin
               cnt_reg <= 8'd0;
            end else if ((state_reg == PROC) && (ch_reg == 3'(gi)) &&
                         err_snap_reg[gi] && (cnt_reg != 8'hFF)) begin
               cnt_reg <= cnt_reg + 8'd1;
            end
         end
         assign err_cnt[gi] = cnt_reg;
`else
         assign err_cnt[gi] = 8'd0;
`endif
      end
   endgenerate

endmodule

// File: tb/tb_adc_avg_monitor.sv
// Self-checking bench for adc_avg_monitor: scoreboard of expected scan results popped on avg_valid.
module tb_adc_avg_monitor;
   localparam int K  = 4;
   localparam int HI = 900;
   localparam int LO = 800;

   logic            clk = 1'b0;
   logic            sclr;
   logic            adc_valid;
   logic [7:0][9:0] adc;
   logic [7:0]      err;
   logic [7:0][9:0] avg;
   logic [7:0]      alarm;
   logic            avg_valid;
   logic            busy;
   logic            overrun;
   logic [7:0][7:0] err_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   adc_avg_monitor dut (
      .clk       (clk),
      .sclr      (sclr),
      .adc_valid (adc_valid),
      .adc       (adc),
      .err       (err),
      .avg       (avg),
      .alarm     (alarm),
      .avg_valid (avg_valid),
      .busy      (busy),
      .overrun   (overrun),
      .err_cnt   (err_cnt)
   );

   typedef struct {
      logic [7:0][9:0] avg;
      logic [7:0]      alarm;
      logic [7:0][7:0] cnt;
   } exp_t;

   exp_t            sb[$];
   int              m_acc    [8];
   bit              m_primed [8];
   logic [7:0][9:0] m_avg;
   logic [7:0]      m_alarm;
   logic [7:0][7:0] m_cnt;

   function automatic void model_reset();
      for (int i = 0; i < 8; i++) begin
         m_acc[i]    = 0;
         m_primed[i] = 1'b0;
      end
      m_avg   = '0;
      m_alarm = '0;
      m_cnt   = '0;
      sb.delete();
   endfunction

   function automatic void model_push(input logic [7:0][9:0] a, input logic [7:0] e);
      exp_t x;
      for (int i = 0; i < 8; i++) begin
         if (e[i]) begin
`ifdef ADC_AVG_ERR_CNT_EN
            if (m_cnt[i] != 8'd255) m_cnt[i] = m_cnt[i] + 8'd1;
`endif
         end else begin
            if (!m_primed[i]) m_acc[i] = int'(a[i]) * (1 << K);
            else              m_acc[i] = m_acc[i] - m_acc[i] / (1 << K) + int'(a[i]);
            m_primed[i] = 1'b1;
            m_avg[i]    = 10'(m_acc[i] / (1 << K));
            if (int'(m_avg[i]) >= HI)      m_alarm[i] = 1'b1;
            else if (int'(m_avg[i]) <= LO) m_alarm[i] = 1'b0;
         end
      end
      x.avg   = m_avg;
      x.alarm = m_alarm;
      x.cnt   = m_cnt;
      sb.push_back(x);
   endfunction

   // Scoreboard: every avg_valid pops one expected scan result.
   always @(negedge clk) begin
      exp_t x;
      if (avg_valid === 1'b1) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected_avg_valid got=1 want=0 t=%0t", $time);
         end else begin
            x = sb.pop_front();
            total++;
            if (avg !== x.avg) begin
               bad++;
               $display("FAIL sb_avg got=%h want=%h t=%0t", avg, x.avg, $time);
            end
            total++;
            if (alarm !== x.alarm) begin
               bad++;
               $display("FAIL sb_alarm got=%h want=%h t=%0t", alarm, x.alarm, $time);
            end
            total++;
            if (err_cnt !== x.cnt) begin
               bad++;
               $display("FAIL sb_err_cnt got=%h want=%h t=%0t", err_cnt, x.cnt, $time);
            end
         end
      end
   end

   function automatic logic [7:0][9:0] rand_scan();
      logic [7:0][9:0] a;
      for (int i = 0; i < 8; i++) a[i] = 10'($urandom_range(0, 1023));
      return a;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      sclr      = 1'b1;
      adc_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      sclr = 1'b0;
      model_reset();
   endtask

   // Drives one accepted scan; returns cycles to avg_valid (-1 on timeout) and busy cycle count.
   task automatic send_scan(input logic [7:0][9:0] a, input logic [7:0] e,
                            output int lat, output int nbusy);
      @(negedge clk);
      adc       = a;
      err       = e;
      adc_valid = 1'b1;
      model_push(a, e);
      lat   = -1;
      nbusy = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         adc_valid = 1'b0;
         adc       = ~a;
         err       = ~e;
         if (busy === 1'b1) nbusy++;
         if (avg_valid === 1'b1) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      sclr      = 1'b1;
      adc_valid = 1'b1;
      adc       = rand_scan();
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || overrun !== 1'b0) begin
         bad++;
         $display("FAIL reset_vs_valid busy=%b overrun=%b want=0,0", busy, overrun);
      end
      sclr      = 1'b0;
      adc_valid = 1'b0;
      model_reset();
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || avg_valid !== 1'b0 || overrun !== 1'b0) begin
         bad++;
         $display("FAIL reset_ctrl busy=%b avg_valid=%b overrun=%b want=000", busy, avg_valid, overrun);
      end
      total++;
      if (avg !== '0 || alarm !== '0 || err_cnt !== '0) begin
         bad++;
         $display("FAIL reset_data avg=%h alarm=%h err_cnt=%h want=0", avg, alarm, err_cnt);
      end
   endtask

   task automatic test_prime();
      logic [7:0][9:0] a;
      int lat, nb;
      do_reset();
      a    = rand_scan();
      a[0] = 10'h2AA;
      a[7] = 10'h155;
      send_scan(a, 8'h00, lat, nb);
      total++;
      if (lat != 9 || nb != 8) begin
         bad++;
         $display("FAIL prime_timing lat=%0d busy_cycles=%0d want=9,8", lat, nb);
      end
      total++;
      if (avg[0] !== 10'h2AA || avg[7] !== 10'h155) begin
         bad++;
         $display("FAIL prime_avg avg0=%h avg7=%h want=2aa,155", avg[0], avg[7]);
      end
   endtask

   task automatic test_filter();
      logic [7:0][9:0] a;
      int lat, nb;
      do_reset();
      a    = rand_scan();
      a[1] = 10'd0;
      send_scan(a, 8'h00, lat, nb);
      a    = rand_scan();
      a[1] = 10'd1023;
      send_scan(a, 8'h00, lat, nb);
      total++;
      if (avg[1] !== 10'd63) begin
         bad++;
         $display("FAIL filter_step got=%0d want=63", avg[1]);
      end
      for (int n = 0; n < 128; n++) begin
         a    = rand_scan();
         a[1] = 10'd1023;
         send_scan(a, 8'h00, lat, nb);
      end
      total++;
      if (avg[1] < 10'd1000) begin
         bad++;
         $display("FAIL filter_settle got=%0d want>=1000", avg[1]);
      end
   endtask

   task automatic test_hysteresis();
      logic [7:0][9:0] a;
      int  lat, nb, inband;
      bit  seen_low, seen_high, want;
      do_reset();
      a    = rand_scan();
      a[2] = 10'd1000;
      send_scan(a, 8'h00, lat, nb);
      total++;
      if (alarm[2] !== 1'b1) begin
         bad++;
         $display("FAIL hyst_set got=%b want=1", alarm[2]);
      end
      seen_low = 1'b0;
      inband   = 0;
      for (int n = 0; n < 40 && !seen_low; n++) begin
         a    = rand_scan();
         a[2] = 10'd0;
         send_scan(a, 8'h00, lat, nb);
         if (int'(m_avg[2]) <= LO) seen_low = 1'b1;
         else if (int'(m_avg[2]) < HI) inband++;
         want = !seen_low;
         total++;
         if (alarm[2] !== want) begin
            bad++;
            $display("FAIL hyst_fall avg=%0d got=%b want=%b", avg[2], alarm[2], want);
         end
      end
      total++;
      if (!seen_low || inband == 0) begin
         bad++;
         $display("FAIL hyst_cover low=%b inband=%0d want=1,>0", seen_low, inband);
      end
      seen_high = 1'b0;
      for (int n = 0; n < 60 && !seen_high; n++) begin
         a    = rand_scan();
         a[2] = 10'd1000;
         send_scan(a, 8'h00, lat, nb);
         if (int'(m_avg[2]) >= HI) seen_high = 1'b1;
         want = seen_high;
         total++;
         if (alarm[2] !== want) begin
            bad++;
            $display("FAIL hyst_rise avg=%0d got=%b want=%b", avg[2], alarm[2], want);
         end
      end
   endtask

   task automatic test_errors();
      logic [7:0][9:0] a;
      logic [7:0]      want3, want255;
      int lat, nb;
`ifdef ADC_AVG_ERR_CNT_EN
      want3   = 8'd3;
      want255 = 8'd255;
`else
      want3   = 8'd0;
      want255 = 8'd0;
`endif
      do_reset();
      a    = rand_scan();
      a[3] = 10'd500;
      send_scan(a, 8'h00, lat, nb);
      for (int n = 0; n < 3; n++) begin
         a    = rand_scan();
         a[3] = 10'd100 + 10'(n);
         send_scan(a, 8'h08, lat, nb);
         total++;
         if (avg[3] !== 10'd500) begin
            bad++;
            $display("FAIL err_hold scan=%0d got=%0d want=500", n, avg[3]);
         end
      end
      total++;
      if (err_cnt[3] !== want3) begin
         bad++;
         $display("FAIL err_cnt3 got=%0d want=%0d", err_cnt[3], want3);
      end
      for (int n = 0; n < 297; n++) begin
         a = rand_scan();
         send_scan(a, 8'h08, lat, nb);
      end
      total++;
      if (err_cnt[3] !== want255) begin
         bad++;
         $display("FAIL err_cnt_sat got=%0d want=%0d", err_cnt[3], want255);
      end
   endtask

   task automatic test_overrun();
      logic [7:0][9:0] a, b;
      int lat;
      do_reset();
      a = rand_scan();
      b = rand_scan();
      @(negedge clk);
      adc       = a;
      err       = 8'h00;
      adc_valid = 1'b1;
      model_push(a, 8'h00);
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         adc_valid = (k == 3 || k == 9);
         adc       = (k == 9) ? b : rand_scan();
         if (k == 9) model_push(b, 8'h00);
         #1;
         total++;
         if (overrun !== (k == 3)) begin
            bad++;
            $display("FAIL ovr_pulse cycle=T+%0d got=%b want=%b", k, overrun, (k == 3));
         end
         if (k == 9) begin
            total++;
            if (avg_valid !== 1'b1 || busy !== 1'b0) begin
               bad++;
               $display("FAIL ovr_done avg_valid=%b busy=%b want=1,0", avg_valid, busy);
            end
         end
      end
      @(negedge clk);
      adc_valid = 1'b0;
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL ovr_accept_in_done busy=%b want=1", busy);
      end
      lat = -1;
      for (int k = 11; k <= 30; k++) begin
         @(negedge clk);
         if (avg_valid === 1'b1) begin
            lat = k;
            break;
         end
      end
      total++;
      if (lat != 18) begin
         bad++;
         $display("FAIL ovr_second_scan lat=T+%0d want=T+18", lat);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0][9:0] a, c;
      int lat, nb;
      do_reset();
      a    = rand_scan();
      a[0] = 10'd1000;
      @(negedge clk);
      adc       = a;
      err       = 8'h00;
      adc_valid = 1'b1;
      model_push(a, 8'h00);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         adc_valid = 1'b0;
      end
      @(negedge clk);
      sclr = 1'b1;
      total++;
      if (alarm[0] !== 1'b1 || avg[0] !== 10'd1000) begin
         bad++;
         $display("FAIL mid_pre alarm0=%b avg0=%0d want=1,1000", alarm[0], avg[0]);
      end
      @(negedge clk);
      sclr = 1'b0;
      model_reset();
      total++;
      if (busy !== 1'b0 || avg !== '0 || alarm !== '0) begin
         bad++;
         $display("FAIL mid_reset busy=%b avg=%h alarm=%h want=0", busy, avg, alarm);
      end
      for (int k = 6; k <= 12; k++) begin
         @(negedge clk);
         total++;
         if (avg_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_no_valid cycle=T+%0d got=%b want=0", k, avg_valid);
         end
      end
      c = rand_scan();
      send_scan(c, 8'h00, lat, nb);
      total++;
      if (lat != 9 || avg !== c) begin
         bad++;
         $display("FAIL mid_reprime lat=%0d avg=%h want=9,%h", lat, avg, c);
      end
   endtask

   initial begin
      sclr      = 1'b1;
      adc_valid = 1'b0;
      adc       = '0;
      err       = '0;
      model_reset();
      repeat (3) @(negedge clk);
      sclr = 1'b0;
      test_reset();
      test_prime();
      test_filter();
      test_hysteresis();
      test_errors();
      test_overrun();
      test_reset_mid();
      repeat (3) @(negedge clk);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL sb_leftover got=%0d want=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
